// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
package counter_pkg;

    // Range-end behaviour selectors
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Width used by the helpers so that any counter up to 32 bits can share them
    localparam int unsigned HELPER_W = 32;

    // Clamp a value into 0..modulus-1 (values at or above modulus become modulus-1)
    function automatic logic [HELPER_W-1:0] clamp_to_range(
        input logic [HELPER_W-1:0] val,
        input logic [HELPER_W-1:0] modulus
    );
        return (val < modulus) ? val : (modulus - HELPER_W'(1));
    endfunction

    // True when val sits at the end of the range in the given direction
    function automatic logic at_range_end(
        input logic [HELPER_W-1:0] val,
        input logic                up,
        input logic [HELPER_W-1:0] modulus
    );
        return up ? (val == (modulus - HELPER_W'(1))) : (val == '0);
    endfunction

endpackage

// File: rtl/count_next.sv
// Combinational next-count and range-end detection for the up/down modulo counter.
module count_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic             up,
    input  logic             en,
    output logic [WIDTH-1:0] next_val_c,
    output logic             range_end_c
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

    logic at_end;

    assign at_end = at_range_end(HELPER_W'(cur_val), up, HELPER_W'(MODULUS));

    // Step one position in the selected direction, wrapping or holding at the ends
    always_comb begin
        next_val_c  = cur_val;
        range_end_c = 1'b0;
        if (en) begin
            if (at_end) begin
                range_end_c = 1'b1;
                if (!SAT_MODE) begin
                    next_val_c = up ? '0 : MAX_VAL;
                end
            end else if (up) begin
                next_val_c = cur_val + WIDTH'(1);
            end else begin
                next_val_c = cur_val - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear, clamped load, wrap pulse and sticky overflow.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cur_val,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] next_val_c;
    logic             range_end_c;
    logic [WIDTH-1:0] ld_clamped;
    logic [WIDTH-1:0] val_d;
    logic             wrap_d;
    logic             ovf_d;

    count_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_count_next (
        .cur_val     (cur_val),
        .up          (up),
        .en          (en),
        .next_val_c  (next_val_c),
        .range_end_c (range_end_c)
    );

    // Out-of-range load values are pulled down to the top of the range
    assign ld_clamped = WIDTH'(clamp_to_range(HELPER_W'(ld_val), HELPER_W'(MODULUS)));

    // Terminal count is the raw range-end condition, independent of clr/ld
    assign tc = range_end_c;

    // Next-state selection: clr > ld > en, otherwise hold
    always_comb begin
        val_d  = cur_val;
        wrap_d = 1'b0;
        ovf_d  = ovf;
        if (clr) begin
            val_d = '0;
            ovf_d = 1'b0;
        end else if (ld) begin
            val_d = ld_clamped;
        end else if (en) begin
            val_d = next_val_c;
            if (range_end_c) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous reset overriding everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_val <= '0;
            wrap    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            cur_val <= val_d;
            wrap    <= wrap_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter MODULUS, default 16, making the count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 The block SHALL have parameter SATURATE, default 0, selecting wrap (0) or saturate (1) at range ends.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-006 The block SHALL have port clr, input, 1, synchronous clear of count and sticky flag.
REQ-007 The block SHALL have port ld, input, 1, the load strobe.
REQ-008 The block SHALL have port ld_val, input, WIDTH, the load value.
REQ-009 The block SHALL have port en, input, 1, the count enable.
REQ-010 The block SHALL have port up, input, 1, the count direction: 1 counts up, 0 counts down.
REQ-011 The block SHALL have port cur_val, output, WIDTH, the registered count.
REQ-012 The block SHALL have port tc, output, 1, the combinational terminal count.
REQ-013 The block SHALL have port wrap, output, 1, a registered one-cycle pulse on a range-end event.
REQ-014 The block SHALL have port ovf, output, 1, a registered sticky flag for range-end events.

Function
REQ-015 Per edge, priority SHALL be rst > clr > ld > en; with none active, all state SHALL hold.
REQ-016 clr SHALL set cur_val=0, ovf=0 and wrap=0.
REQ-017 ld SHALL set cur_val=ld_val when ld_val < MODULUS, else MODULUS-1 (clamp); wrap=0; ovf SHALL be unchanged.
REQ-018 en with up=1 and cur_val < MODULUS-1 SHALL increment by 1; en with up=0 and cur_val > 0 SHALL decrement by 1.
REQ-019 A range-end event is en=1 with (up=1, cur_val=MODULUS-1) or (up=0, cur_val=0).
REQ-020 On a range-end event with SATURATE=0, cur_val SHALL wrap to 0 (up) or to MODULUS-1 (down).
REQ-021 On a range-end event with SATURATE=1, cur_val SHALL hold.
REQ-022 On a range-end event, wrap SHALL be 1 in the following cycle only, and ovf SHALL be set.
REQ-023 ovf SHALL remain set until clr or rst.
REQ-024 In every cycle that is not a range-end event, wrap SHALL be 0.
REQ-025 tc SHALL equal en & ((up & cur_val==MODULUS-1) | (~up & cur_val==0)), with no register stage.
REQ-026 All arithmetic SHALL be WIDTH bits wide; no internal value outside 0..MODULUS-1 SHALL reach cur_val.
REQ-027 Direction changes SHALL take effect in the same cycle, with no pipeline or turnaround delay.

Reset
REQ-028 rst=1 at a rising edge SHALL force cur_val=0, wrap=0, ovf=0, regardless of clr, ld or en.
REQ-029 Reset asserted mid-count SHALL discard the in-flight update; counting SHALL resume from 0 on the first edge after rst deasserts.

Structure
REQ-030 Package counter_pkg SHALL hold the mode constants (MODE_WRAP=0, MODE_SAT=1) and a clamp/compare helper function shared with future counter variants.
REQ-031 A single combinational sub-module, count_next, SHALL compute the next value and the range-end flag from cur_val, up, en, MODULUS and SATURATE.
REQ-032 updown_mod_counter SHALL instantiate count_next and own all registers.

Verification (WIDTH=4, MODULUS=10)
REQ-033 Bench SHALL check: rst held for 2 cycles while ld=1, ld_val=5 -> cur_val=0, ovf=0, wrap=0.
REQ-034 Bench SHALL check: SATURATE=0, up=1, en=1 from 0 for 10 cycles -> 0..9 then 0; tc=1 at 9; wrap=1 one cycle after 9->0; ovf=1 and stays set.
REQ-035 Bench SHALL check: SATURATE=1, up=0, en=1 from 2 -> 1, 0, 0, 0; wrap pulses after each hold at 0.
REQ-036 Bench SHALL check: ld=1, ld_val=13 -> cur_val=9; ld and en together with ld_val=3 -> cur_val=3, no increment.
REQ-037 Bench SHALL check: clr and ld together at cur_val=7 with ovf=1 -> cur_val=0, ovf=0.
REQ-038 Bench SHALL check: up toggled every cycle with en=1 starting at 4 -> 5, 4, 5, 4; tc=0 and wrap=0 throughout.
